multicycle_control_fsm: RTL

//  Multi-cycle successor to the single-cycle opcode decoder of the Antares-R2 core.

---
 rtl/multicycle_control_fsm_if.sv | 33 +++
 rtl/multicycle_control_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control interface between the multi-cycle control FSM and the datapath.
// master: the control FSM (drives enables, samples opcode and memory acknowledge).
// slave:  the datapath / instruction register side.
interface multicycle_control_fsm_if;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic [1:0] branch;
  logic       jump;
  logic [1:0] reg_dst;
  logic       alu_src;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       md_start;
  logic       md_op;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  op_code, mem_ready,
    output pc_write, ir_write, branch, jump, reg_dst, alu_src, mem_read, mem_write,
           mem_to_reg, reg_write, md_start, md_op, illegal, state
  );

  modport slave (
    output op_code, mem_ready,
    input  pc_write, ir_write, branch, jump, reg_dst, alu_src, mem_read, mem_write,
           mem_to_reg, reg_write, md_start, md_op, illegal, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM for the Antares-R2 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, holds in MEM until mem_ready, and waits in
// MDWAIT for the MUL/DIV unit. Define ANTARES_MULDIV_EN to decode MUL, DIV and MFHI;
// otherwise those opcodes are treated as illegal and MDWAIT is never entered.
module multicycle_control_fsm #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StMdwait = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsRtype, ClsImm, ClsJ, ClsJal, ClsBeq, ClsBne,
    ClsLoad, ClsStore, ClsMfhi, ClsMul, ClsDiv
  } cls_e;

  // ClsNone doubles as "illegal opcode".
  function automatic cls_e decode_op(input logic [5:0] op);
    cls_e c;
    c = ClsNone;
    casez (op)
      6'b000000: c = ClsRtype;
      6'b000010: c = ClsJ;
      6'b000011: c = ClsJal;
      6'b000100: c = ClsBeq;
      6'b000101: c = ClsBne;
      6'b001???: c = ClsImm;
      6'b100???: c = ClsLoad;
      6'b101???: c = ClsStore;
`ifdef ANTARES_MULDIV_EN
      6'b010000: c = ClsMfhi;
      6'b011010: c = ClsDiv;
      6'b011100: c = ClsMul;
`else
      6'b010000, 6'b011010, 6'b011100: c = ClsNone;
`endif
      default:   c = ClsNone;
    endcase
    return c;
  endfunction

  state_e           state_q;
  cls_e             cls_q;
  logic [CNT_W-1:0] cnt_q;
  cls_e             op_cls;

  assign op_cls = decode_op(bus.op_code);

  // State, latched opcode class and MUL/DIV stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cls_q   <= ClsNone;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          cls_q   <= op_cls;
          state_q <= (op_cls == ClsNone) ? StFetch : StExec;
        end
        StExec: begin
          case (cls_q)
            ClsRtype, ClsImm, ClsMfhi: state_q <= StWb;
            ClsLoad, ClsStore:         state_q <= StMem;
            ClsMul: begin
              cnt_q   <= CNT_W'(MUL_CYCLES - 1);
              state_q <= StMdwait;
            end
            ClsDiv: begin
              cnt_q   <= CNT_W'(DIV_CYCLES - 1);
              state_q <= StMdwait;
            end
            default: state_q <= StFetch;
          endcase
        end
        StMem: begin
          if (bus.mem_ready) begin
            state_q <= (cls_q == ClsLoad) ? StWb : StFetch;
          end
        end
        StMdwait: begin
          if (cnt_q == '0) begin
            // DIV result lands in HI/LO, so no register-file write-back.
            state_q <= (cls_q == ClsMul) ? StWb : StFetch;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StWb:    state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  logic       pc_write, ir_write, jump, alu_src, mem_read, mem_write;
  logic       reg_write, md_start, md_op, illegal;
  logic [1:0] branch, reg_dst, mem_to_reg;
  logic [2:0] state_out;

  // Moore decode of datapath enables; everything is forced low while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 2'b00;
    jump       = 1'b0;
    reg_dst    = 2'b00;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    md_start   = 1'b0;
    md_op      = 1'b0;
    illegal    = 1'b0;
    state_out  = 3'd0;
    if (!reset) begin
      state_out = state_q;
      case (state_q)
        StFetch: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        // The IR was loaded at the end of FETCH, so op_code is valid here.
        StDecode: illegal = (op_cls == ClsNone);
        StExec: begin
          case (cls_q)
            ClsImm, ClsLoad, ClsStore: alu_src = 1'b1;
            ClsBeq: branch = 2'b01;
            ClsBne: branch = 2'b10;
            ClsJ:   jump   = 1'b1;
            ClsJal: begin
              jump       = 1'b1;
              reg_write  = 1'b1;
              reg_dst    = 2'b10;
              mem_to_reg = 2'b10;
            end
`ifdef ANTARES_MULDIV_EN
            ClsMul: md_start = 1'b1;
            ClsDiv: begin
              md_start = 1'b1;
              md_op    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        StMem: begin
          mem_read  = (cls_q == ClsLoad);
          mem_write = (cls_q == ClsStore);
        end
        StWb: begin
          reg_write = 1'b1;
          case (cls_q)
            ClsRtype, ClsMul: reg_dst = 2'b01;
            ClsLoad:          mem_to_reg = 2'b01;
            ClsMfhi: begin
              reg_dst    = 2'b01;
              mem_to_reg = 2'b11;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.branch     = branch;
  assign bus.jump       = jump;
  assign bus.reg_dst    = reg_dst;
  assign bus.alu_src    = alu_src;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.md_start   = md_start;
  assign bus.md_op      = md_op;
  assign bus.illegal    = illegal;
  assign bus.state      = state_out;

endmodule
